tdm_demux: RTL and testbench

TDM_DEMUX -- requirements
Module: tdm_demux

---
 rtl/tdm_demux.sv | 100 ++++++++++
 tb/tb_tdm_demux.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux.sv
// TDM frame demultiplexer: collects CHANNELS serial words per frame, aligned on
// in_sof, and publishes each complete frame atomically on a wide output bus.
module tdm_demux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int SW       = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic                      in_sof,
  input  logic [WIDTH-1:0]          in_data,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      out_valid,
  output logic [SW-1:0]             slot,
  output logic                      locked,
  output logic                      frame_err
);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [SW-1:0]           slot_next;
  logic [SW-1:0]           store_idx;
  logic                    store;
  logic                    publish;
  logic                    err;
  logic [WIDTH-1:0]        shadow [CHANNELS];
  logic [CHANNELS*WIDTH-1:0] frame;

  // Framing decisions; an SOF word always lands in slot 0 regardless of state.
  always_comb begin
    state_next = state;
    slot_next  = slot;
    store      = 1'b0;
    publish    = 1'b0;
    err        = 1'b0;
    store_idx  = in_sof ? '0 : slot;
    if (in_valid) begin
      case (state)
        HUNT: begin
          if (in_sof) begin
            store      = 1'b1;
            slot_next  = SW'(1);
            state_next = RUN;
          end
        end
        RUN: begin
          if (in_sof) begin
            store     = 1'b1;
            slot_next = SW'(1);
            err       = (slot != '0);
          end else if (slot == '0) begin
            err        = 1'b1;
            state_next = HUNT;
          end else begin
            store     = 1'b1;
            slot_next = slot + SW'(1);
            publish   = (slot == SW'(CHANNELS - 1));
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  // The word currently being accepted replaces its slot so the published frame is complete.
  always_comb begin
    frame = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (SW'(k) == slot) frame[k*WIDTH +: WIDTH] = in_data;
      else                frame[k*WIDTH +: WIDTH] = shadow[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      slot      <= '0;
      locked    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) shadow[k] <= '0;
    end else begin
      state     <= state_next;
      slot      <= slot_next;
      locked    <= (state_next == RUN);
      out_valid <= publish;
      frame_err <= err;
      if (store) shadow[store_idx] <= in_data;
      if (publish) out_data <= frame;
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Directed self-checking bench for tdm_demux with default parameters.
module tb_tdm_demux;

  localparam int W  = 8;
  localparam int C  = 8;
  localparam int SW = 3;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_sof;
  logic [W-1:0]   in_data;
  logic [C*W-1:0] out_data;
  logic           out_valid;
  logic [SW-1:0]  slot;
  logic           locked;
  logic           frame_err;

  int checks;
  int fails;
  int pv_cnt;
  int fe_cnt;

  tdm_demux #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
    .in_data(in_data), .out_data(out_data), .out_valid(out_valid),
    .slot(slot), .locked(locked), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus; outputs are sampled 1ns after the edge and pulses tallied.
  task automatic drive(input logic v, input logic s, input logic [W-1:0] d);
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    @(posedge clk);
    #1;
    if (out_valid) pv_cnt++;
    if (frame_err) fe_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 8'h99);
    checks++;
    if (locked !== 1'b0 || slot !== 3'd0) begin
      fails++; $display("[TB] FAIL reset_accept: locked=%b slot=%0d, required locked=0 slot=0", locked, slot);
    end
    checks++;
    if (out_data !== 64'h0 || out_valid !== 1'b0 || frame_err !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_outputs: out_data=%h out_valid=%b frame_err=%b, required all 0", out_data, out_valid, frame_err);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_basic_frame();
    pv_cnt = 0; fe_cnt = 0;
    drive(1'b1, 1'b1, 8'h10);
    checks++;
    if (locked !== 1'b1 || slot !== 3'd1) begin
      fails++; $display("[TB] FAIL basic_lock: locked=%b slot=%0d, required locked=1 slot=1", locked, slot);
    end
    for (int i = 1; i < 7; i++) drive(1'b1, 1'b0, 8'h10 + W'(i));
    checks++;
    if (out_valid !== 1'b0 || out_data !== 64'h0) begin
      fails++; $display("[TB] FAIL basic_partial: out_valid=%b out_data=%h, required 0 / 0", out_valid, out_data);
    end
    drive(1'b1, 1'b0, 8'h17);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'h1716151413121110) begin
      fails++; $display("[TB] FAIL basic_publish: out_valid=%b out_data=%h, required 1 / 1716151413121110", out_valid, out_data);
    end
    checks++;
    if (slot !== 3'd0 || locked !== 1'b1) begin
      fails++; $display("[TB] FAIL basic_wrap: slot=%0d locked=%b, required slot=0 locked=1", slot, locked);
    end
    drive(1'b0, 1'b0, 8'h00);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 64'h1716151413121110) begin
      fails++; $display("[TB] FAIL basic_hold: out_valid=%b out_data=%h, required 0 / 1716151413121110", out_valid, out_data);
    end
    checks++;
    if (pv_cnt !== 1 || fe_cnt !== 0) begin
      fails++; $display("[TB] FAIL basic_pulses: out_valid pulses=%0d frame_err pulses=%0d, required 1 / 0", pv_cnt, fe_cnt);
    end
  endtask

  task automatic test_gaps();
    pv_cnt = 0; fe_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, (i == 0), 8'h10 + W'(i));
      if (i == 7) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 64'h1716151413121110) begin
          fails++; $display("[TB] FAIL gaps_publish: out_valid=%b out_data=%h, required 1 / 1716151413121110", out_valid, out_data);
        end
      end
      for (int g = 0; g < 3; g++) drive(1'b0, 1'b1, 8'hEE);
      checks++;
      if (slot !== SW'(i + 1)) begin
        fails++; $display("[TB] FAIL gaps_slot_hold: slot=%0d, required %0d", slot, (i + 1) % 8);
      end
    end
    checks++;
    if (pv_cnt !== 1 || fe_cnt !== 0 || locked !== 1'b1) begin
      fails++; $display("[TB] FAIL gaps_pulses: out_valid=%0d frame_err=%0d locked=%b, required 1 / 0 / 1", pv_cnt, fe_cnt, locked);
    end
  endtask

  task automatic test_hunt_discard();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    pv_cnt = 0; fe_cnt = 0;
    drive(1'b1, 1'b0, 8'hAA);
    drive(1'b1, 1'b0, 8'hBB);
    checks++;
    if (locked !== 1'b0 || slot !== 3'd0 || fe_cnt !== 0) begin
      fails++; $display("[TB] FAIL hunt_discard: locked=%b slot=%0d frame_err=%0d, required 0 / 0 / 0", locked, slot, fe_cnt);
    end
    for (int i = 0; i < 8; i++) drive(1'b1, (i == 0), 8'hC0 + W'(i));
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'hC7C6C5C4C3C2C1C0 || pv_cnt !== 1) begin
      fails++; $display("[TB] FAIL hunt_frame: out_valid=%b out_data=%h pulses=%0d, required 1 / C7C6C5C4C3C2C1C0 / 1", out_valid, out_data, pv_cnt);
    end
  endtask

  task automatic test_early_sof();
    pv_cnt = 0; fe_cnt = 0;
    for (int i = 0; i < 4; i++) drive(1'b1, (i == 0), 8'h20 + W'(i));
    drive(1'b1, 1'b1, 8'h30);
    checks++;
    if (frame_err !== 1'b1 || out_valid !== 1'b0 || slot !== 3'd1 || locked !== 1'b1) begin
      fails++; $display("[TB] FAIL early_sof_err: frame_err=%b out_valid=%b slot=%0d locked=%b, required 1 / 0 / 1 / 1", frame_err, out_valid, slot, locked);
    end
    for (int i = 1; i < 8; i++) begin
      drive(1'b1, 1'b0, 8'h30 + W'(i));
      if (i == 1) begin
        checks++;
        if (frame_err !== 1'b0) begin
          fails++; $display("[TB] FAIL early_sof_pulse: frame_err=%b, required 0", frame_err);
        end
      end
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'h3736353433323130) begin
      fails++; $display("[TB] FAIL early_sof_frame: out_valid=%b out_data=%h, required 1 / 3736353433323130", out_valid, out_data);
    end
    checks++;
    if (pv_cnt !== 1 || fe_cnt !== 1) begin
      fails++; $display("[TB] FAIL early_sof_pulses: out_valid=%0d frame_err=%0d, required 1 / 1", pv_cnt, fe_cnt);
    end
  endtask

  task automatic test_missing_sof();
    pv_cnt = 0; fe_cnt = 0;
    drive(1'b1, 1'b0, 8'h55);
    checks++;
    if (frame_err !== 1'b1 || locked !== 1'b0 || slot !== 3'd0) begin
      fails++; $display("[TB] FAIL missing_sof_err: frame_err=%b locked=%b slot=%0d, required 1 / 0 / 0", frame_err, locked, slot);
    end
    checks++;
    if (out_data !== 64'h3736353433323130 || out_valid !== 1'b0) begin
      fails++; $display("[TB] FAIL missing_sof_hold: out_data=%h out_valid=%b, required 3736353433323130 / 0", out_data, out_valid);
    end
    drive(1'b1, 1'b0, 8'h66);
    checks++;
    if (frame_err !== 1'b0 || fe_cnt !== 1 || locked !== 1'b0) begin
      fails++; $display("[TB] FAIL missing_sof_hunt: frame_err=%b pulses=%0d locked=%b, required 0 / 1 / 0", frame_err, fe_cnt, locked);
    end
  endtask

  task automatic test_mid_reset();
    pv_cnt = 0; fe_cnt = 0;
    for (int i = 0; i < 4; i++) drive(1'b1, (i == 0), 8'h40 + W'(i));
    checks++;
    if (slot !== 3'd4 || locked !== 1'b1) begin
      fails++; $display("[TB] FAIL mid_reset_pre: slot=%0d locked=%b, required 4 / 1", slot, locked);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_data !== 64'h0 || slot !== 3'd0 || locked !== 1'b0 || out_valid !== 1'b0 || frame_err !== 1'b0) begin
      fails++; $display("[TB] FAIL mid_reset_async: out_data=%h slot=%0d locked=%b out_valid=%b frame_err=%b, required all 0", out_data, slot, locked, out_valid, frame_err);
    end
    drive(1'b1, 1'b1, 8'h99);
    in_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 4; i < 8; i++) drive(1'b1, 1'b0, 8'h40 + W'(i));
    checks++;
    if (locked !== 1'b0 || pv_cnt !== 0 || out_data !== 64'h0) begin
      fails++; $display("[TB] FAIL mid_reset_abort: locked=%b pulses=%0d out_data=%h, required 0 / 0 / 0", locked, pv_cnt, out_data);
    end
    for (int i = 0; i < 8; i++) drive(1'b1, (i == 0), 8'h50 + W'(i));
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'h5756555453525150 || pv_cnt !== 1) begin
      fails++; $display("[TB] FAIL mid_reset_frame: out_valid=%b out_data=%h pulses=%0d, required 1 / 5756555453525150 / 1", out_valid, out_data, pv_cnt);
    end
  endtask

  initial begin
    checks = 0; fails = 0; pv_cnt = 0; fe_cnt = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    test_reset();
    test_basic_frame();
    test_gaps();
    test_hunt_discard();
    test_early_sof();
    test_missing_sof();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
